// File: rtl/fx3_pkg.sv
// Shared types and constants for the FX3 multi-thread stream writer.
package fx3_pkg;

  localparam int ADDR_W      = 2;
  localparam int MAX_THREADS = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WAIT,
    SEND,
    PAUSE,
    SHORT,
    NEXT
  } state_t;

  // Round-robin successor of a thread index, wrapping at threads-1.
  function automatic logic [ADDR_W-1:0] next_thread(input logic [ADDR_W-1:0] cur,
                                                     input int threads);
    if (cur >= ADDR_W'(threads - 1)) return '0;
    else return cur + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/fx3_flag_sync.sv
// Single register stage on every FX3 / FIFO input, plus a mux that presents
// the flags of the currently selected thread.
module fx3_flag_sync
  import fx3_pkg::*;
#(
  parameter int THREADS = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               nready,
  input  logic [THREADS-1:0] th_ready,
  input  logic [THREADS-1:0] th_watermark,
  input  logic               almost_empty,
  input  logic [ADDR_W-1:0]  sel,
  output logic               enable_q,
  output logic               nready_q,
  output logic               almost_empty_q,
  output logic               ready_sel,
  output logic               watermark_sel
);

  logic [THREADS-1:0] th_ready_q;
  logic [THREADS-1:0] th_watermark_q;

  // Capture all inputs; reset values read as "not ready / nothing to send".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q       <= 1'b0;
      nready_q       <= 1'b1;
      almost_empty_q <= 1'b1;
      th_ready_q     <= '0;
      th_watermark_q <= '0;
    end else begin
      enable_q       <= enable;
      nready_q       <= nready;
      almost_empty_q <= almost_empty;
      th_ready_q     <= th_ready;
      th_watermark_q <= th_watermark;
    end
  end

  // Select the captured flags of the active thread.
  always_comb begin
    ready_sel     = 1'b0;
    watermark_sel = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      if (sel == ADDR_W'(i)) begin
        ready_sel     = th_ready_q[i];
        watermark_sel = th_watermark_q[i];
      end
    end
  end

endmodule

// File: rtl/fx3_stream_writer.sv
// Round-robin FX3 slave-FIFO write controller.
//
//   state | meaning
//   IDLE  | streaming disabled, outputs inactive
//   SETUP | address driven, waiting ADDR_SETUP cycles for thread flags to settle
//   WAIT  | waiting for thread ready, watermark, GPIF ready and sample data
//   SEND  | one word written per cycle
//   PAUSE | sample FIFO underrun inside a packet, write strobe held off
//   SHORT | packet-end strobe held SHORT_HOLD cycles to commit a partial buffer
//   NEXT  | turnaround, advance to the next thread
module fx3_stream_writer
  import fx3_pkg::*;
#(
  parameter int THREADS      = 2,
  parameter int PKT_WORDS    = 8192,
  parameter int ADDR_SETUP   = 3,
  parameter int IDLE_TIMEOUT = 64,
  parameter int SHORT_HOLD   = 2
) (
  input  logic               fx3_clock,
  input  logic               fx3_nReset,
  input  logic               enable,
  input  logic               fx3_nReady,
  input  logic [THREADS-1:0] fx3_thReady,
  input  logic [THREADS-1:0] fx3_thWatermark,
  input  logic               fifoAlmostEmpty,
  output logic [ADDR_W-1:0]  fx3_address,
  output logic               fx3_nWrite,
  output logic               fx3_nShort,
  output logic               fifoRead,
  output logic [15:0]        shortCount,
  output logic               busy
);

  localparam int WC_W = $clog2(PKT_WORDS + 1);
  localparam int SC_W = $clog2(ADDR_SETUP + 1);
  localparam int IC_W = $clog2(IDLE_TIMEOUT + 1);
  localparam int HC_W = $clog2(SHORT_HOLD + 1);

  localparam logic [WC_W-1:0] WC_LAST    = WC_W'(PKT_WORDS - 1);
  localparam logic [SC_W-1:0] SETUP_LAST = SC_W'(ADDR_SETUP - 1);
  localparam logic [IC_W-1:0] IDLE_LAST  = IC_W'(IDLE_TIMEOUT - 1);
  localparam logic [HC_W-1:0] HOLD_LAST  = HC_W'(SHORT_HOLD - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sel_q, sel_d;
  logic [WC_W-1:0]   wc_q, wc_d;
  logic [SC_W-1:0]   setup_q, setup_d;
  logic [IC_W-1:0]   idle_q, idle_d;
  logic [HC_W-1:0]   hold_q, hold_d;
  logic [15:0]       short_q, short_d;

  logic en_q, nready_q, ae_q, ready_sel, wm_sel;
  logic flags_ok;

  fx3_flag_sync #(
    .THREADS (THREADS)
  ) u_flag_sync (
    .clk            (fx3_clock),
    .rst_n          (fx3_nReset),
    .enable         (enable),
    .nready         (fx3_nReady),
    .th_ready       (fx3_thReady),
    .th_watermark   (fx3_thWatermark),
    .almost_empty   (fifoAlmostEmpty),
    .sel            (sel_q),
    .enable_q       (en_q),
    .nready_q       (nready_q),
    .almost_empty_q (ae_q),
    .ready_sel      (ready_sel),
    .watermark_sel  (wm_sel)
  );

  assign flags_ok = ready_sel & wm_sel & ~nready_q & ~ae_q;

  // State and counter registers.
  always_ff @(posedge fx3_clock or negedge fx3_nReset) begin
    if (!fx3_nReset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      wc_q    <= '0;
      setup_q <= '0;
      idle_q  <= '0;
      hold_q  <= '0;
      short_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      wc_q    <= wc_d;
      setup_q <= setup_d;
      idle_q  <= idle_d;
      hold_q  <= hold_d;
      short_q <= short_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    wc_d    = wc_q;
    setup_d = setup_q;
    idle_d  = idle_q;
    hold_d  = hold_q;
    short_d = short_q;
    case (state_q)
      IDLE: begin
        setup_d = '0;
        if (en_q) state_d = SETUP;
      end
      SETUP: begin
        if (setup_q == SETUP_LAST) begin
          setup_d = '0;
          state_d = WAIT;
        end else begin
          setup_d = setup_q + SC_W'(1);
        end
      end
      WAIT: begin
        if (!en_q)         state_d = IDLE;
        else if (flags_ok) state_d = SEND;
      end
      SEND: begin
        // The word written this cycle always makes the packet non-empty, so
        // leaving via SHORT from here never commits a zero-length packet.
        if (wc_q == WC_LAST || !wm_sel) begin
          wc_d    = '0;
          state_d = NEXT;
        end else if (!en_q) begin
          wc_d    = wc_q + WC_W'(1);
          hold_d  = '0;
          state_d = SHORT;
        end else if (ae_q) begin
          wc_d    = wc_q + WC_W'(1);
          idle_d  = '0;
          state_d = PAUSE;
        end else begin
          wc_d    = wc_q + WC_W'(1);
        end
      end
      PAUSE: begin
        if (!ae_q) begin
          idle_d  = '0;
          state_d = SEND;
        end else if (idle_q == IDLE_LAST || !en_q) begin
          idle_d  = '0;
          hold_d  = '0;
          state_d = SHORT;
        end else begin
          idle_d  = idle_q + IC_W'(1);
        end
      end
      SHORT: begin
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          wc_d    = '0;
          state_d = NEXT;
          if (short_q != 16'hFFFF) short_d = short_q + 16'd1;
        end else begin
          hold_d  = hold_q + HC_W'(1);
        end
      end
      NEXT: begin
        sel_d   = next_thread(sel_q, THREADS);
        state_d = en_q ? SETUP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the next state so they line up with the state register.
  always_ff @(posedge fx3_clock or negedge fx3_nReset) begin
    if (!fx3_nReset) begin
      fx3_nWrite  <= 1'b1;
      fx3_nShort  <= 1'b1;
      busy        <= 1'b0;
      fx3_address <= '0;
    end else begin
      fx3_nWrite  <= (state_d != SEND);
      fx3_nShort  <= (state_d != SHORT);
      busy        <= (state_d != IDLE);
      fx3_address <= sel_d;
    end
  end

  assign fifoRead   = ~fx3_nWrite;
  assign shortCount = short_q;

endmodule

// File: tb/tb_fx3_stream_writer.sv
// Directed bench for fx3_stream_writer (2 threads, 16-word packets).
module tb_fx3_stream_writer;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       nready;
  logic [1:0] th_ready;
  logic [1:0] th_wm;
  logic       ae;
  logic [1:0] fx3_address;
  logic       fx3_nWrite;
  logic       fx3_nShort;
  logic       fifoRead;
  logic [15:0] shortCount;
  logic       busy;

  int checks;
  int failures;
  int cyc;
  int words;
  int short_low;
  int first_short;
  int proto_err;
  bit prev_nwrite;
  int burst_len[$];
  logic [1:0] burst_addr[$];

  fx3_stream_writer #(
    .THREADS      (2),
    .PKT_WORDS    (16),
    .ADDR_SETUP   (3),
    .IDLE_TIMEOUT (64),
    .SHORT_HOLD   (2)
  ) dut (
    .fx3_clock       (clk),
    .fx3_nReset      (rst_n),
    .enable          (enable),
    .fx3_nReady      (nready),
    .fx3_thReady     (th_ready),
    .fx3_thWatermark (th_wm),
    .fifoAlmostEmpty (ae),
    .fx3_address     (fx3_address),
    .fx3_nWrite      (fx3_nWrite),
    .fx3_nShort      (fx3_nShort),
    .fifoRead        (fifoRead),
    .shortCount      (shortCount),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_counters();
    cyc         = 0;
    words       = 0;
    short_low   = 0;
    first_short = -1;
    prev_nwrite = 1'b1;
    burst_len.delete();
    burst_addr.delete();
  endtask

  // Advance one clock and sample outputs 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (fx3_nWrite === 1'b0) begin
      words++;
      if (prev_nwrite) begin
        burst_len.push_back(0);
        burst_addr.push_back(fx3_address);
      end
      burst_len[burst_len.size()-1] = burst_len[burst_len.size()-1] + 1;
    end
    if (fx3_nShort === 1'b0) begin
      short_low++;
      if (first_short < 0) first_short = cyc;
    end
    if (fifoRead !== ~fx3_nWrite) proto_err++;
    if (fx3_nShort === 1'b0 && fx3_nWrite === 1'b0) proto_err++;
    prev_nwrite = fx3_nWrite;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_words(input int target, input int limit, output bit ok);
    int n;
    n = 0;
    while (words < target && n < limit) begin
      step();
      n++;
    end
    ok = (words >= target);
  endtask

  // Reset the DUT mid-cycle, then start streaming with all flags good.
  task automatic restart();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    enable   = 1'b0;
    nready   = 1'b0;
    th_ready = 2'b11;
    th_wm    = 2'b11;
    ae       = 1'b0;
    #2;
    rst_n    = 1'b1;
    clear_counters();
    enable   = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    enable   = 1'b0;
    nready   = 1'b1;
    th_ready = 2'b00;
    th_wm    = 2'b00;
    ae       = 1'b1;
    clear_counters();
    proto_err = 0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (fx3_nWrite !== 1'b1) begin failures++; $display("FAIL reset_nwrite: got %b want 1", fx3_nWrite); end
    checks++; if (fx3_nShort !== 1'b1) begin failures++; $display("FAIL reset_nshort: got %b want 1", fx3_nShort); end
    checks++; if (fifoRead !== 1'b0) begin failures++; $display("FAIL reset_fiforead: got %b want 0", fifoRead); end
    checks++; if (fx3_address !== 2'd0) begin failures++; $display("FAIL reset_address: got %0d want 0", fx3_address); end
    checks++; if (shortCount !== 16'd0) begin failures++; $display("FAIL reset_shortcount: got %0d want 0", shortCount); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    int n;
    bit busy_seen;
    nready   = 1'b0;
    th_ready = 2'b11;
    th_wm    = 2'b11;
    ae       = 1'b0;
    clear_counters();
    enable   = 1'b1;
    n = 0;
    busy_seen = 1'b0;
    while (words == 0 && n < 20) begin
      step();
      n++;
      if (n == 2) busy_seen = busy;
    end
    checks++; if (n !== 6) begin failures++; $display("FAIL first_write_latency: got %0d cycles want 6", n); end
    checks++; if (busy_seen !== 1'b1) begin failures++; $display("FAIL busy_in_setup: got %b want 1", busy_seen); end
    checks++; if (fx3_address !== 2'd0) begin failures++; $display("FAIL first_address: got %0d want 0", fx3_address); end
  endtask

  task automatic test_full_bursts();
    int n;
    n = 0;
    while (!(burst_len.size() >= 3 && burst_len[burst_len.size()-1] == 16) && n < 150) begin
      step();
      n++;
    end
    checks++; if (burst_len.size() < 3) begin failures++; $display("FAIL bursts_timeout: got %0d bursts want 3", burst_len.size()); end
    else begin
      checks++; if (burst_len[0] !== 16) begin failures++; $display("FAIL burst0_len: got %0d want 16", burst_len[0]); end
      checks++; if (burst_len[1] !== 16) begin failures++; $display("FAIL burst1_len: got %0d want 16", burst_len[1]); end
      checks++; if (burst_addr[0] !== 2'd0) begin failures++; $display("FAIL burst0_addr: got %0d want 0", burst_addr[0]); end
      checks++; if (burst_addr[1] !== 2'd1) begin failures++; $display("FAIL burst1_addr: got %0d want 1", burst_addr[1]); end
      checks++; if (burst_addr[2] !== 2'd0) begin failures++; $display("FAIL burst2_addr: got %0d want 0", burst_addr[2]); end
    end
    checks++; if (short_low !== 0) begin failures++; $display("FAIL bursts_nshort: got %0d low cycles want 0", short_low); end
    checks++; if (shortCount !== 16'd0) begin failures++; $display("FAIL bursts_shortcount: got %0d want 0", shortCount); end
  endtask

  task automatic test_underrun_resume();
    bit ok;
    restart();
    wait_words(4, 30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL resume_start_timeout: got %0d words want 4", words); end
    ae = 1'b1;
    steps(10);
    checks++; if (words !== 5) begin failures++; $display("FAIL resume_paused_words: got %0d want 5", words); end
    ae = 1'b0;
    wait_words(16, 60, ok);
    steps(3);
    checks++; if (words !== 16) begin failures++; $display("FAIL resume_total_words: got %0d want 16", words); end
    checks++; if (burst_len.size() !== 2) begin failures++; $display("FAIL resume_bursts: got %0d want 2", burst_len.size()); end
    else begin
      checks++; if (burst_len[1] !== 11) begin failures++; $display("FAIL resume_tail_len: got %0d want 11", burst_len[1]); end
    end
    checks++; if (short_low !== 0 || shortCount !== 16'd0) begin failures++; $display("FAIL resume_no_short: got low=%0d count=%0d want 0 0", short_low, shortCount); end
  endtask

  task automatic test_underrun_short();
    bit ok;
    int c0;
    restart();
    wait_words(4, 30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL short_start_timeout: got %0d words want 4", words); end
    c0 = cyc;
    ae = 1'b1;
    steps(80);
    checks++; if (words !== 5) begin failures++; $display("FAIL short_words: got %0d want 5", words); end
    checks++; if (short_low !== 2) begin failures++; $display("FAIL short_pulse_len: got %0d want 2", short_low); end
    checks++; if (first_short - c0 !== 66) begin failures++; $display("FAIL short_timeout_pos: got %0d want 66", first_short - c0); end
    checks++; if (shortCount !== 16'd1) begin failures++; $display("FAIL short_count: got %0d want 1", shortCount); end
    checks++; if (fx3_address !== 2'd1) begin failures++; $display("FAIL short_next_thread: got %0d want 1", fx3_address); end
    ae = 1'b0;
    wait_words(6, 30, ok);
    checks++; if (!ok || burst_addr[burst_addr.size()-1] !== 2'd1) begin failures++; $display("FAIL short_resume_addr: got words=%0d want next burst on thread 1", words); end
  endtask

  task automatic test_watermark();
    bit ok;
    restart();
    wait_words(11, 30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wm_start_timeout: got %0d words want 11", words); end
    th_wm = 2'b00;
    steps(10);
    checks++; if (words !== 12) begin failures++; $display("FAIL wm_stop_words: got %0d want 12", words); end
    checks++; if (fx3_address !== 2'd1) begin failures++; $display("FAIL wm_next_thread: got %0d want 1", fx3_address); end
    checks++; if (short_low !== 0 || shortCount !== 16'd0) begin failures++; $display("FAIL wm_no_short: got low=%0d count=%0d want 0 0", short_low, shortCount); end
    th_wm = 2'b11;
    wait_words(13, 30, ok);
    checks++; if (!ok || burst_addr[burst_addr.size()-1] !== 2'd1) begin failures++; $display("FAIL wm_resume_addr: got words=%0d want next burst on thread 1", words); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    restart();
    wait_words(6, 30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL en_start_timeout: got %0d words want 6", words); end
    enable = 1'b0;
    steps(10);
    checks++; if (words !== 7) begin failures++; $display("FAIL en_drop_words: got %0d want 7", words); end
    checks++; if (short_low !== 2) begin failures++; $display("FAIL en_drop_pulse: got %0d want 2", short_low); end
    checks++; if (shortCount !== 16'd1) begin failures++; $display("FAIL en_drop_count: got %0d want 1", shortCount); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL en_drop_idle: got busy=%b want 0", busy); end
    checks++; if (fx3_address !== 2'd1) begin failures++; $display("FAIL en_drop_addr: got %0d want 1", fx3_address); end
  endtask

  task automatic test_enable_drop_empty();
    restart();
    nready = 1'b1;
    steps(8);
    checks++; if (busy !== 1'b1 || words !== 0) begin failures++; $display("FAIL empty_wait: got busy=%b words=%0d want 1 0", busy, words); end
    enable = 1'b0;
    steps(5);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL empty_idle: got busy=%b want 0", busy); end
    checks++; if (short_low !== 0 || shortCount !== 16'd0) begin failures++; $display("FAIL empty_no_short: got low=%0d count=%0d want 0 0", short_low, shortCount); end
  endtask

  task automatic test_reset_mid_send();
    bit ok;
    restart();
    wait_words(24, 100, ok);
    checks++; if (!ok || fx3_address !== 2'd1 || fx3_nWrite !== 1'b0) begin failures++; $display("FAIL midrst_pre: got words=%0d addr=%0d nwrite=%b want 24 1 0", words, fx3_address, fx3_nWrite); end
    rst_n = 1'b0;
    #1;
    checks++; if (fx3_nWrite !== 1'b1 || fifoRead !== 1'b0) begin failures++; $display("FAIL midrst_write: got nwrite=%b read=%b want 1 0", fx3_nWrite, fifoRead); end
    checks++; if (fx3_address !== 2'd0) begin failures++; $display("FAIL midrst_address: got %0d want 0", fx3_address); end
    checks++; if (busy !== 1'b0 || fx3_nShort !== 1'b1) begin failures++; $display("FAIL midrst_busy: got busy=%b nshort=%b want 0 1", busy, fx3_nShort); end
    step();
    rst_n = 1'b1;
    clear_counters();
    wait_words(1, 20, ok);
    checks++; if (!ok || cyc !== 6) begin failures++; $display("FAIL midrst_restart_latency: got %0d want 6", cyc); end
    checks++; if (!ok || burst_addr[0] !== 2'd0) begin failures++; $display("FAIL midrst_restart_thread: want thread 0, words=%0d", words); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_latency();
    test_full_bursts();
    test_underrun_resume();
    test_underrun_short();
    test_watermark();
    test_enable_drop();
    test_enable_drop_empty();
    test_reset_mid_send();
    checks++; if (proto_err !== 0) begin failures++; $display("FAIL strobe_protocol: got %0d bad cycles want 0", proto_err); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fx3_stream_writer.md
# fx3_stream_writer

Parametrised multi-thread FX3 slave-FIFO write controller. It moves sample words from the local sample FIFO into up to four FX3 DMA threads in round-robin order. It counts words per DMA buffer and handles sample-FIFO underrun by pausing; a short packet is committed only after a timeout. It sits between the sample FIFO (show-ahead read port) and the FX3 GPIF pins, and it is the successor to the single-thread FX3 state machine.

## Interface
- THREADS, 2, number of FX3 threads used (1-4), cycled 0..THREADS-1
- PKT_WORDS, 8192, words per FX3 DMA buffer (full packet), ≥ 8
- ADDR_SETUP, 3, cycles after a thread-address change before that thread's flags are trusted
- IDLE_TIMEOUT, 64, consecutive underrun cycles in a partly filled packet before a short packet is committed
- SHORT_HOLD, 2, cycles fx3_nShort is held low
- fx3_clock  in  1  sole clock
- fx3_nReset  in  1  asynchronous, active-low reset
- enable  in  1  streaming enable (capture running)
- fx3_nReady  in  1  FX3 GPIF ready, active low
- fx3_thReady  in  THREADS  per-thread DMA-ready flag
- fx3_thWatermark  in  THREADS  per-thread watermark; 1 = buffer has room, 0 = near full
- fifoAlmostEmpty  in  1  sample FIFO below its safe-read level
- fx3_address  out  2  selected thread, zero-extended
- fx3_nWrite  out  1  FX3 write strobe, active low
- fx3_nShort  out  1  FX3 packet-end strobe, active low
- fifoRead  out  1  sample-FIFO read acknowledge
- shortCount  out  16  saturating count of short packets committed
- busy  out  1  high whenever state ≠ IDLE

## Operation
- All inputs are registered once on fx3_clock before use. This is the 1-cycle flag delay.
- States:
  - IDLE: outputs inactive. Goes to SETUP when enable=1.
  - SETUP: fx3_address is driven; counts ADDR_SETUP cycles, then goes to WAIT.
  - WAIT: goes to SEND when thReady[sel]=1, watermark[sel]=1, nReady=0 and fifoAlmostEmpty=0. If enable=0, goes to IDLE.
  - SEND: one word per cycle. wordCount increments each cycle.
    - wordCount reaches PKT_WORDS-1 (last word written this cycle), or watermark[sel]=0: go to NEXT with wordCount cleared.
    - fifoAlmostEmpty=1: go to PAUSE.
    - enable=0: go to SHORT if wordCount>0.
  - PAUSE: nWrite high and idleCount increments.
    - fifoAlmostEmpty=0: back to SEND.
    - idleCount = IDLE_TIMEOUT-1, or enable=0: go to SHORT.
  - SHORT: fx3_nShort low and nWrite high for SHORT_HOLD cycles. Commits the partial buffer. shortCount increments once. wordCount clears. Then goes to NEXT.
  - NEXT: one turnaround cycle. sel advances (wraps from THREADS-1 to 0). Then goes to SETUP, or to IDLE if enable=0.
- Priority in SEND: packet complete > enable drop > underrun.
- Zero-length packets are never sent. A short packet is committed only when wordCount>0.
- When THREADS=1, sel stays 0 and SETUP still runs.
- Reset mid-packet: all state is discarded. The host-side driver handles resynchronisation.

## Timing
- Reset values:
  - fx3_nWrite=1, fx3_nShort=1, fifoRead=0
  - fx3_address=0, shortCount=0, busy=0
  - state=IDLE, sel=0
- Outputs are registered and decoded from the next state, so they align exactly with the state register.
  - fx3_nWrite is low exactly in SEND cycles.
  - fifoRead = ~fx3_nWrite in the same cycle; the FIFO is show-ahead.
- Latency: first nWrite low is at least ADDR_SETUP+2 cycles after enable rises, given all flags are good.
- A full packet is exactly PKT_WORDS nWrite-low cycles, summed across any PAUSE gaps.
- wordCount width is $clog2(PKT_WORDS+1); it never exceeds PKT_WORDS.
- shortCount saturates at 16'hFFFF.

## Structure
- Shared package fx3_pkg holds:
  - the state enum (IDLE, SETUP, WAIT, SEND, PAUSE, SHORT, NEXT)
  - the address width constant (2)
  - the maximum thread count (4)
- One sub-module, fx3_flag_sync: a registered capture of nReady, thReady, thWatermark and fifoAlmostEmpty, with a per-thread mux of the selected thread's flags.

## Test plan
- THREADS=2, PKT_WORDS=16, all flags good -> bursts of 16 nWrite-low cycles; fx3_address alternates 0,1,0; nShort never low.
- Underrun after 5 words for 10 cycles, IDLE_TIMEOUT=64 -> PAUSE then SEND resumes; the packet still totals 16 words; shortCount=0.
- Underrun after 5 words held 64 cycles -> nShort low for exactly 2 cycles with nWrite high; shortCount=1; the next thread is selected.
- Watermark[sel] falls after 12 words -> transfer stops after 12 words; thread advances; no short packet.
- enable drops after 7 words -> short packet committed, then IDLE. If it drops at wordCount=0 -> IDLE with no nShort pulse.
- fx3_nReset asserted mid-SEND -> all outputs return to their reset values immediately (asynchronously); after release, streaming restarts at thread 0.
